res_pack: RTL and testbench

Readback packer for the distance-transform datapath. After the result RAM holds one 8-bit value per pixel for the 128x128 image, this block reads all 16384 pixels in order. It reduces each pixel to one bit and packs 16 consecutive pixels, MSB first, into each 16-bit word. The words are written to a 1024-word sti-format memory, so the block is the inverse of the bit-to-byte initialisation path and lets the bench round-trip an image.

---
 rtl/res_pack.sv | 97 +++++++++
 tb/tb_res_pack.sv | 126 ++++++++++++
 2 files changed

// File: rtl/res_pack.sv
// res_pack: reads 16384 result bytes, reduces each to one bit and packs 16 per word MSB first.
// PACK_NONZERO_EN selects b = |res_di; otherwise b = res_di[0].
module res_pack #(
    parameter logic [9:0] LAST_WORD = 10'h3FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pack_en,
    output logic        busy,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        pk_wr,
    output logic [9:0]  pk_addr,
    output logic [15:0] pk_do,
    output logic        pack_done
);
    localparam logic [13:0] PIX_LAST = {LAST_WORD, 4'hF};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t      state, state_nx;
    logic [13:0] pix;
    logic [9:0]  word;
    logic [3:0]  bit_cnt;
    logic [15:0] shift;
    logic        valid;
    logic        drain_cnt;
    logic        b;

`ifdef PACK_NONZERO_EN
    assign b = |res_di;
`else
    logic unused_hi;
    assign b = res_di[0];
    assign unused_hi = ^res_di[7:1];
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pack_en ? READ : IDLE;
            READ:    state_nx = (pix == PIX_LAST) ? DRAIN : READ;
            DRAIN:   state_nx = drain_cnt ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state == READ) || (state == DRAIN);
    assign res_rd    = (state == READ);
    assign res_addr  = pix;
    assign pack_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix       <= '0;
            word      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            valid     <= 1'b0;
            drain_cnt <= 1'b0;
            pk_wr     <= 1'b0;
            pk_addr   <= '0;
            pk_do     <= '0;
        end else begin
            valid     <= res_rd;
            pk_wr     <= 1'b0;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (state == READ && pix != PIX_LAST)
                pix <= pix + 14'd1;
            if (valid) begin
                shift   <= {shift[14:0], b};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) begin
                    pk_do   <= {shift[14:0], b};
                    pk_addr <= word;
                    pk_wr   <= 1'b1;
                    word    <= word + 10'd1;
                end
            end
            // a new pass always starts from a clean word boundary
            if (state == IDLE && pack_en) begin
                pix     <= '0;
                word    <= '0;
                bit_cnt <= '0;
                shift   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_res_pack.sv
// tb_res_pack: random and directed passes of res_pack against a pixel-array model.
module tb_res_pack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pack_en = 1'b0;
    logic        busy, res_rd, pk_wr, pack_done;
    logic [13:0] res_addr;
    logic [7:0]  res_di = 8'h00;
    logic [9:0]  pk_addr;
    logic [15:0] pk_do;

    logic [7:0]  mem [16384];
    logic [15:0] exp_w [1024];
    int          n_chk = 0;
    int          n_pass = 0;

    res_pack dut (
        .clk(clk), .reset(reset), .pack_en(pack_en), .busy(busy),
        .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
        .pk_wr(pk_wr), .pk_addr(pk_addr), .pk_do(pk_do), .pack_done(pack_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (res_rd) res_di <= mem[res_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic bit pix_bit(input logic [7:0] v);
`ifdef PACK_NONZERO_EN
        return v != 8'h00;
`else
        return v[0];
`endif
    endfunction

    task automatic build_model();
        for (int k = 0; k < 1024; k++) begin
            int w = 0;
            for (int i = 0; i < 16; i++)
                if (pix_bit(mem[16 * k + i])) w += 1 << (15 - i);
            exp_w[k] = 16'(w);
        end
    endtask

    task automatic run_pass(input int pulse_at, input int abort_at);
        int  writes = 0;
        bit  done = 0;
        build_model();
        @(negedge clk); pack_en = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 17000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            pack_en = (cyc == pulse_at);
            if (cyc == 0) begin
                check("busy_c0", busy, 1);
                check("rd_c0", res_rd, 1);
                check("addr_c0", res_addr, 0);
            end
            if (cyc == 100) check("addr_c100", res_addr, 100);
            if (cyc == 18) check("hold_w0", {pk_wr, pk_do}, {1'b0, exp_w[0]});
            if (pk_wr) begin
                check("wr_addr", pk_addr, writes);
                check("wr_data", pk_do, exp_w[writes & 1023]);
                check("wr_cycle", cyc, 16 * writes + 17);
                writes++;
            end
            if (cyc == 16385) check("busy_c16385", busy, 1);
            if (pack_done) begin
                check("done_cycle", cyc, 16386);
                check("write_count", writes, 1024);
                check("busy_at_done", busy, 0);
                done = 1;
            end
            if (cyc == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_zero", {busy, res_rd, res_addr, pk_wr, pk_addr, pk_do, pack_done}, 0);
                reset = 1'b1;
                @(negedge clk);
                check("abort_idle", {busy, pk_wr}, 0);
                return;
            end
        end
        if (!done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", {pack_done, busy}, 0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, res_rd, res_addr, pk_wr, pk_addr, pk_do, pack_done}, 0);
        pack_en = 1'b1;
        @(negedge clk);
        check("rst_ignores_en", busy, 0);
        pack_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_rst", busy, 0);

        run_pass(-1, -1);

        mem[0] = 8'h01;
        mem[16383] = 8'h01;
        mem[5] = 8'h06;
        for (int i = 0; i < 16; i++) mem[16 + i] = (i % 2 == 0) ? 8'h01 : 8'h00;
        run_pass(-1, -1);

        for (int i = 0; i < 16384; i++) mem[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        run_pass(5000, -1);
        run_pass(-1, 100);
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(0, 3));
        run_pass(-1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
